// File: rtl/riscv_pkg.sv
// riscv_pkg: shared constants for the load/store unit.
//   OPC_LOAD / OPC_STORE : major opcodes accepted by the LSU
//   F3_*                 : func3 access size/sign encodings
//   lsu_state_t          : LSU control FSM states
package riscv_pkg;
  localparam logic [6:0] OPC_LOAD  = 7'h03;
  localparam logic [6:0] OPC_STORE = 7'h23;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT_RD = 2'd2,
    DONE    = 2'd3
  } lsu_state_t;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane steering for the LSU.
// Ports:
//   st_func3_i, st_off_i, st_data_i -> be_o, wdata_o  (store side)
//   ld_func3_i, ld_off_i, ld_data_i -> ld_result_o    (load side)
// Offsets are byte offsets within the 32-bit word, already forced aligned
// by the caller where alignment is not trapped.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  st_func3_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  input  logic [2:0]  ld_func3_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] ld_data_i,
  output logic [31:0] ld_result_o
);
  logic [31:0] ld_shift;

  // Store: byte enables follow the size, data is replicated so whichever
  // lane is enabled already carries the right bytes.
  always_comb begin
    be_o    = 4'hF;
    wdata_o = st_data_i;
    case (st_func3_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << st_off_i;
        wdata_o = {4{st_data_i[7:0]}};
      end
      2'b01: begin
        be_o    = 4'b0011 << {st_off_i[1], 1'b0};
        wdata_o = {2{st_data_i[15:0]}};
      end
      default: begin
        be_o    = 4'hF;
        wdata_o = st_data_i;
      end
    endcase
  end

  // Load: bring the addressed lane down to bit 0, then extend.
  always_comb begin
    ld_shift    = ld_data_i >> {ld_off_i, 3'b000};
    ld_result_o = 32'h0;
    case (ld_func3_i)
      F3_B:    ld_result_o = {{24{ld_shift[7]}}, ld_shift[7:0]};
      F3_BU:   ld_result_o = {24'h0, ld_shift[7:0]};
      F3_H:    ld_result_o = {{16{ld_shift[15]}}, ld_shift[15:0]};
      F3_HU:   ld_result_o = {16'h0, ld_shift[15:0]};
      F3_W:    ld_result_o = ld_data_i;
      default: ld_result_o = 32'h0;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding RV32 load/store unit.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_*_i / req_ready_o    core request (opcode, func3, address, store data)
//   mem_*_o / mem_ready_i    word-aligned memory request with byte enables
//   mem_rvalid_i/rdata_i     read return
//   rsp_valid_o, rdata_o     one-cycle completion with extended load data
//   err_o, misalign_o        illegal / misaligned status, valid with rsp
// Build option: define LSU_MISALIGN_TRAP_EN to report misaligned halfword
// and word accesses instead of silently aligning them.
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic [6:0]    opcode_i,
  input  logic [2:0]    func3_i,
  input  logic [DW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic          mem_valid_o,
  input  logic          mem_ready_i,
  output logic          mem_we_o,
  output logic [DW-1:0] mem_addr_o,
  output logic [3:0]    mem_be_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic          mem_rvalid_i,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          rsp_valid_o,
  output logic [DW-1:0] rdata_o,
  output logic          err_o,
  output logic          misalign_o
);
  lsu_state_t    state_q, state_d;
  logic [DW-1:0] addr_q, addr_d;
  logic [3:0]    be_q, be_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          we_q, we_d;
  logic [2:0]    func3_q, func3_d;
  logic [1:0]    off_q, off_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          mis_q, mis_d;

  logic          is_load, is_store, illegal, mis_raw, mis_req;
  logic [1:0]    off_req;
  logic [3:0]    be_req;
  logic [DW-1:0] wdata_req, ld_res;

  assign is_load  = (opcode_i == OPC_LOAD);
  assign is_store = (opcode_i == OPC_STORE);
  assign illegal  = !((is_load && (func3_i inside {F3_B, F3_H, F3_W, F3_BU, F3_HU})) ||
                      (is_store && (func3_i inside {F3_B, F3_H, F3_W})));
  assign mis_raw  = ((func3_i[1:0] == 2'b01) && addr_i[0]) ||
                    ((func3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));

`ifdef LSU_MISALIGN_TRAP_EN
  assign mis_req = mis_raw && !illegal;
  assign off_req = addr_i[1:0];
`else
  // Offending low bits are dropped so the access lands on its natural boundary.
  assign mis_req = 1'b0;
  always_comb begin
    case (func3_i[1:0])
      2'b00:   off_req = addr_i[1:0];
      2'b01:   off_req = {addr_i[1], 1'b0};
      default: off_req = 2'b00;
    endcase
  end
`endif

  // Store steering is evaluated on the live request; load extraction on the
  // registered access with the returning read word.
  lsu_align u_align (
    .st_func3_i  (func3_i),
    .st_off_i    (off_req),
    .st_data_i   (wdata_i),
    .be_o        (be_req),
    .wdata_o     (wdata_req),
    .ld_func3_i  (func3_q),
    .ld_off_i    (off_q),
    .ld_data_i   (mem_rdata_i),
    .ld_result_o (ld_res)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    func3_d = func3_q;
    off_d   = off_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mis_d   = mis_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          addr_d  = {addr_i[DW-1:2], 2'b00};
          be_d    = be_req;
          wdata_d = wdata_req;
          we_d    = is_store;
          func3_d = func3_i;
          off_d   = off_req;
          rdata_d = '0;
          err_d   = illegal;
          mis_d   = mis_req;
          // Faulting requests skip the memory side entirely.
          state_d = (illegal || mis_req) ? DONE : REQ;
        end
      end
      REQ: begin
        if (mem_ready_i) state_d = we_q ? DONE : WAIT_RD;
      end
      WAIT_RD: begin
        if (mem_rvalid_i) begin
          rdata_d = ld_res;
          state_d = DONE;
        end
      end
      DONE: begin
        err_d   = 1'b0;
        mis_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      func3_q <= '0;
      off_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      func3_q <= func3_d;
      off_q   <= off_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign mem_valid_o = (state_q == REQ);
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_be_o    = be_q;
  assign mem_wdata_o = wdata_q;
  assign rsp_valid_o = (state_q == DONE);
  assign rdata_o     = rdata_q;
  assign err_o       = err_q;
  assign misalign_o  = mis_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed cases plus randomized transactions
// against a behavioural model; memory side responds with random stalls.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i, req_ready_o;
  logic [6:0]  opcode_i;
  logic [2:0]  func3_i;
  logic [31:0] addr_i, wdata_i;
  logic        mem_valid_o, mem_ready_i, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        rsp_valid_o, err_o, misalign_o;
  logic [31:0] rdata_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  load_store_unit #(.DW(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .opcode_i(opcode_i), .func3_i(func3_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .rsp_valid_o(rsp_valid_o), .rdata_o(rdata_o), .err_o(err_o), .misalign_o(misalign_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: what the access should look like, from the RV32 rules.
  task automatic model(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] w, input logic [31:0] rd,
                       output logic acc, output logic we, output logic err, output logic mis,
                       output logic [31:0] ea, output logic [3:0] be,
                       output logic [31:0] wd, output logic [31:0] res);
    int sz, off;
    logic ld, st;
    logic [31:0] sh;
    ld  = (opc == 7'h03);
    st  = (opc == 7'h23);
    err = !((ld && (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5)) || (st && f3 < 3));
    sz  = int'(f3[1:0]);
    off = int'(a[1:0]);
    mis = 1'b0;
    if (!err && ((sz == 1 && a[0]) || (sz == 2 && off != 0))) begin
`ifdef LSU_MISALIGN_TRAP_EN
      mis = 1'b1;
`else
      off = (sz == 1) ? (off & 2) : 0;
`endif
    end
    acc = !err && !mis;
    we  = st;
    ea  = a & 32'hFFFF_FFFC;
    be  = (sz == 0) ? 4'(1 << off) : (sz == 1) ? 4'(3 << off) : 4'hF;
    wd  = (sz == 0) ? 32'(w[7:0]) * 32'h0101_0101 :
          (sz == 1) ? 32'(w[15:0]) * 32'h0001_0001 : w;
    sh  = rd >> (8 * off);
    case (f3)
      3'd0:    res = 32'(sh[7:0])  | (sh[7]  ? 32'hFFFF_FF00 : 32'h0);
      3'd4:    res = 32'(sh[7:0]);
      3'd1:    res = 32'(sh[15:0]) | (sh[15] ? 32'hFFFF_0000 : 32'h0);
      3'd5:    res = 32'(sh[15:0]);
      default: res = rd;
    endcase
    if (!ld || !acc) res = 32'h0;
  endtask

  // One full transaction; entered and left at a negedge.
  task automatic txn(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] w, input logic [31:0] rd,
                     input int stall, input int rdly, input bit junk);
    logic acc, we, err, mis;
    logic [31:0] ea, wd, res;
    logic [3:0] be;
    int t, cyc, st_left, rd_left;
    bit got, hs_pend, hs_done, memv, rv_sent;
    model(opc, f3, a, w, rd, acc, we, err, mis, ea, be, wd, res);
    t = 0;
    while (!req_ready_o && t < 20) begin @(negedge clk); t++; end
    chk("req_ready", 32'(req_ready_o), 1);
    req_valid_i = 1'b1; opcode_i = opc; func3_i = f3; addr_i = a; wdata_i = w;
    @(negedge clk);
    req_valid_i = 1'b0; opcode_i = 7'($urandom); func3_i = 3'($urandom);
    addr_i = $urandom; wdata_i = $urandom;
    cyc = 1; st_left = stall; rd_left = rdly;
    got = 0; hs_pend = 0; hs_done = 0; memv = 0; rv_sent = 0;
    while (!got && cyc <= 100) begin
      if (hs_pend) begin hs_done = 1; hs_pend = 0; end
      mem_ready_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = $urandom;
      if (rsp_valid_o) begin
        got = 1;
      end else begin
        if (mem_valid_o) begin
          memv = 1;
          chk("mem_addr", mem_addr_o, ea);
          chk("mem_we", 32'(mem_we_o), 32'(we));
          if (we) begin
            chk("mem_be", 32'(mem_be_o), 32'(be));
            chk("mem_wdata", mem_wdata_o, wd);
          end
          if (st_left == 0) begin mem_ready_i = 1'b1; hs_pend = 1; end
          else st_left--;
          if (junk && ($urandom_range(0, 1) == 1)) mem_rvalid_i = 1'b1;
        end else if (hs_done && !we && !rv_sent) begin
          if (rd_left == 0) begin mem_rvalid_i = 1'b1; mem_rdata_i = rd; rv_sent = 1; end
          else rd_left--;
        end
        @(negedge clk);
        cyc++;
      end
    end
    mem_ready_i = 1'b0; mem_rvalid_i = 1'b0;
    chk("rsp_seen", 32'(got), 1);
    chk("memv_seen", 32'(memv), 32'(acc));
    if (got) begin
      chk("latency", 32'(cyc), !acc ? 1 : we ? 32'(2 + stall) : 32'(3 + stall + rdly));
      chk("rdata", rdata_o, res);
      chk("err", 32'(err_o), 32'(err));
      chk("misalign", 32'(misalign_o), 32'(mis));
    end
    @(negedge clk);
    chk("rsp_pulse", 32'(rsp_valid_o), 0);
    chk("ready_idle", 32'(req_ready_o), 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(req_ready_o), 1);
    chk({tag, "_memv"},  32'(mem_valid_o), 0);
    chk({tag, "_we"},    32'(mem_we_o), 0);
    chk({tag, "_addr"},  mem_addr_o, 0);
    chk({tag, "_be"},    32'(mem_be_o), 0);
    chk({tag, "_wdata"}, mem_wdata_o, 0);
    chk({tag, "_rsp"},   32'(rsp_valid_o), 0);
    chk({tag, "_rdata"}, rdata_o, 0);
    chk({tag, "_err"},   32'(err_o), 0);
    chk({tag, "_mis"},   32'(misalign_o), 0);
  endtask

  initial begin
    bit rsp_any;
    logic [6:0] opc;
    rst = 1'b1; req_valid_i = 0; opcode_i = 0; func3_i = 0; addr_i = 0; wdata_i = 0;
    mem_ready_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    txn(7'h23, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0, 0, 0, 0);   // SW
    txn(7'h03, 3'b000, 32'h203, 32'h0, 32'h8000_0000, 0, 0, 0);  // LB
    chk("lb_lit", rdata_o, 32'hFFFF_FF80);
    txn(7'h03, 3'b100, 32'h203, 32'h0, 32'h8000_0000, 0, 0, 0);  // LBU
    chk("lbu_lit", rdata_o, 32'h0000_0080);
    txn(7'h23, 3'b001, 32'h102, 32'h0000ABCD, 32'h0, 3, 0, 1);   // SH with stall
    txn(7'h03, 3'b010, 32'h102, 32'h0, 32'h1234_5678, 0, 0, 0);  // LW misaligned
    txn(7'h23, 3'b100, 32'h100, 32'h5555_5555, 32'h0, 0, 0, 0);  // illegal store f3
    txn(7'h13, 3'b000, 32'h100, 32'h0, 32'h0, 0, 0, 0);          // illegal opcode
    txn(7'h03, 3'b011, 32'h100, 32'h0, 32'h0, 0, 0, 0);          // illegal load f3
    txn(7'h03, 3'b101, 32'h302, 32'h0, 32'h9ABC_1234, 1, 2, 1);  // LHU upper half

    // Reset while waiting for read data, then a stray rvalid
    txn(7'h03, 3'b010, 32'h400, 32'h0, 32'h0, 0, 0, 0);
    req_valid_i = 1'b1; opcode_i = 7'h03; func3_i = 3'b010; addr_i = 32'h500;
    @(negedge clk);
    req_valid_i = 1'b0;
    mem_ready_i = 1'b1;
    @(negedge clk);
    mem_ready_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_vals("wrst");
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFE_F00D;
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    rsp_any = 0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid_o) rsp_any = 1;
      @(negedge clk);
    end
    chk("stray_rsp", 32'(rsp_any), 0);
    chk("stray_ready", 32'(req_ready_o), 1);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0:       opc = 7'($urandom);
        1, 2, 3, 4: opc = 7'h23;
        default: opc = 7'h03;
      endcase
      txn(opc, 3'($urandom), $urandom, $urandom, $urandom,
          $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
